// File: rtl/sdram_req_arbiter.sv
// Arbitrates the video read-prefetcher and host write path onto the single SDRAM app port.
// Define ARB_STATS_EN to add wrapping grant / starvation-event counters.
module sdram_req_arbiter #(
  parameter int AW            = 25,
  parameter int BURST_LEN     = 4,
  parameter int WR_STARVE_MAX = 64,
  parameter int URGENT_LEVEL  = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mem_ready,
  input  logic [1:0]    fifo_level,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  output logic          wr_ack,
  output logic          wr_data_next,
  output logic          wr_done,
  output logic          app_req,
  output logic [AW-1:0] app_req_addr,
  output logic          app_req_wr_n,
  output logic [8:0]    app_req_len,
  input  logic          app_req_ack,
  input  logic          app_wr_next_req,
  input  logic          app_last_wr,
`ifdef ARB_STATS_EN
  output logic [15:0]   rd_grants,
  output logic [15:0]   wr_grants,
  output logic [15:0]   starve_events,
`endif
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, WR_DATA} state_t;

  localparam int            SW         = $clog2(WR_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(WR_STARVE_MAX);

  state_t        r_state;
  logic          r_app_req;
  logic [AW-1:0] r_app_addr;
  logic          r_app_wr_n;
  logic          r_rd_ack;
  logic          r_wr_ack;
  logic          r_wr_done;
  logic          r_last_wr;
  logic [SW-1:0] r_starve_cnt;

  logic w_in_wr;
  logic w_urgent;
  logic w_starved;
  logic w_grant_rd;
  logic w_grant_wr;
  logic w_forced;

  assign w_in_wr   = (r_state == WR_REQ) || (r_state == WR_DATA);
  assign w_urgent  = fifo_level <= 2'(URGENT_LEVEL);
  assign w_starved = r_starve_cnt >= STARVE_MAX;

  // Grant priority: urgent read, starved write, alternate, then whichever is pending.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_grant_rd = 1'b0;
    w_grant_wr = 1'b0;
    w_forced   = 1'b0;
    if (mem_ready) begin
      if (rd_req && w_urgent) begin
        w_grant_rd = 1'b1;
      end else if (wr_req && w_starved) begin
        w_grant_wr = 1'b1;
        w_forced   = 1'b1;
      end else if (rd_req && wr_req) begin
        w_grant_rd = r_last_wr;
        w_grant_wr = !r_last_wr;
      end else if (rd_req) begin
        w_grant_rd = 1'b1;
      end else if (wr_req) begin
        w_grant_wr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      r_state      <= IDLE;
      r_app_req    <= 1'b0;
      r_app_addr   <= '0;
      r_app_wr_n   <= 1'b1;
      r_rd_ack     <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_wr_done    <= 1'b0;
      r_last_wr    <= 1'b1;
      r_starve_cnt <= '0;
    end else begin
      r_rd_ack  <= 1'b0;
      r_wr_ack  <= 1'b0;
      r_wr_done <= 1'b0;
      if (wr_req && !w_in_wr && !w_starved)
        r_starve_cnt <= r_starve_cnt + 1'b1;

      case (r_state)
        IDLE: begin
          if (w_grant_rd) begin
            r_state    <= RD_REQ;
            r_app_req  <= 1'b1;
            r_app_addr <= rd_addr;
            r_app_wr_n <= 1'b1;
            r_last_wr  <= 1'b0;
          end else if (w_grant_wr) begin
            r_state    <= WR_REQ;
            r_app_req  <= 1'b1;
            r_app_addr <= wr_addr;
            r_app_wr_n <= 1'b0;
            r_last_wr  <= 1'b1;
          end
        end
        RD_REQ: begin
          if (app_req_ack) begin
            r_app_req <= 1'b0;
            r_rd_ack  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        WR_REQ: begin
          if (app_req_ack) begin
            r_app_req    <= 1'b0;
            r_wr_ack     <= 1'b1;
            r_starve_cnt <= '0;
            if (app_last_wr) begin
              r_wr_done <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_state <= WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (app_last_wr) begin
            r_wr_done <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rd_ack       = r_rd_ack;
  assign wr_ack       = r_wr_ack;
  assign wr_done      = r_wr_done;
  assign wr_data_next = app_wr_next_req && w_in_wr;
  assign app_req      = r_app_req;
  assign app_req_addr = r_app_addr;
  assign app_req_wr_n = r_app_wr_n;
  assign app_req_len  = 9'(BURST_LEN);
  assign busy         = (r_state != IDLE);

`ifdef ARB_STATS_EN
  logic [15:0] r_rd_grants;
  logic [15:0] r_wr_grants;
  logic [15:0] r_starve_events;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_grants     <= '0;
      r_wr_grants     <= '0;
      r_starve_events <= '0;
    end else begin
      if (r_rd_ack)                   r_rd_grants     <= r_rd_grants + 16'd1;
      if (r_wr_ack)                   r_wr_grants     <= r_wr_grants + 16'd1;
      if (r_state == IDLE && w_forced) r_starve_events <= r_starve_events + 16'd1;
    end
  end

  assign rd_grants     = r_rd_grants;
  assign wr_grants     = r_wr_grants;
  assign starve_events = r_starve_events;
`endif

endmodule
